kb_digit_display: RTL and testbench
===================================

Name: kb_digit_display

Overview:
- Consumer end of the keypad scanner's `num`/`en` interface.
- Captures each one-cycle key-press pulse into an 8-digit hex entry buffer, with clear and backspace keys.
- Time-multiplexes the buffer onto an 8-digit common-anode seven-segment display.
- Sits between the keypad scanner and the board display pins, and also exports the entered value for downstream logic.

Parameters:
- SCAN_THRESHOLD, 200000-1, digit dwell time in clk cycles minus 1 (2 ms at 100 MHz); benches use 3.
- CNT_WIDTH, 24, width of the scan dwell counter; must hold SCAN_THRESHOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- num  input  4  key code from the keypad scanner; valid only in cycles where en=1.
- en  input  1  one-cycle key-press strobe.
- led_en  output  8  digit enables, active low; bit i = position i, position 0 = rightmost.
- seg  output  8  segments, active low, {dp,g,f,e,d,c,b,a}; dp is always 1 (off).
- value  output  32  entry buffer; nibble i = position i.
- count  output  4  number of entered digits, 0..8.

Behaviour:
- Reset (asynchronous, rst=1):
  - value=0, count=0, scan index=0, dwell counter=0.
  - led_en=8'hFF, seg=8'hFF.
  - Reset mid-scan or mid-entry takes effect immediately; no partial state survives.
- Key handling, evaluated on a rising clk edge with en=1. value and count update on that edge (1-cycle latency).
  - num 0x0..0xD (digit): value <= {value[27:0], num}; count <= min(count+1, 8).
    - When full (count=8), the oldest digit value[31:28] is discarded and count stays 8.
  - num 0xE (clear): value <= 0, count <= 0.
  - num 0xF (backspace): value <= {4'h0, value[31:4]}; count <= count-1.
    - When empty (count=0), backspace does nothing.
  - With en=0, num is ignored.
  - en held high for several cycles is treated as one key per cycle (the upstream scanner guarantees single-cycle pulses).
- Scan:
  - The dwell counter counts 0..SCAN_THRESHOLD and then wraps to 0. cnt_end = (counter == SCAN_THRESHOLD).
  - The scan index (3 bits) increments on cnt_end and wraps from 7 to 0.
  - The dwell counter runs continuously; it is not gated by en.
- Output stage (registered; led_en and seg update one cycle after the scan index changes or after value/count change):
  - led_en = ~(8'b1 << index) when the position is visible, otherwise 8'hFF.
  - seg = active-low hex glyph of nibble[index], with bit7 = 1.
  - Position visibility depends on KB_BLANK_EN (see Optional Feature).
- Simultaneous events:
  - A key press and cnt_end in the same cycle are both applied.
  - The output register reflects the new value and index on the following edge.
- Glyphs (active-high gfedcba, inverted on output):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71

Optional Feature:
- Macro: KB_BLANK_EN.
- Defined: position i is visible only when i < count. Unentered positions and an empty buffer show nothing (led_en=8'hFF during those slots).
- Undefined: all 8 positions are always visible; unentered positions show "0".

Decomposition:
- Shared package `kb_pkg`, containing:
  - KEY_CLR=4'hE and KEY_BSP=4'hF.
  - DIGITS=8.
  - Active-high glyph constants SEG_0..SEG_F.
  - SEG_BLANK=8'hFF.
- One sub-module: `seg7_decode`, a combinational 4-bit hex to active-low 8-bit seg converter with dp forced off. It is instantiated once after the digit mux.
- The dwell counter is written inline; it has the same shape as the scanner's counter.

Test Plan (SCAN_THRESHOLD=3, KB_BLANK_EN defined unless stated):
1. Assert rst, release, run 40 cycles with en=0 -> led_en=8'hFF, seg=8'hFF, value=0, count=0 throughout.
2. Pulse keys 1, 2, 3 -> value=32'h00000123, count=3; in index-0 slot led_en=8'hFE and seg=8'hB0; in index-3 slot led_en=8'hFF.
3. Pulse keys 1..9 -> value=32'h23456789, count=8; index-7 slot shows seg=8'hA4 ("2") with led_en=8'h7F.
4. After entering 1, 2, 3, pulse 0xF -> value=32'h00000012, count=2. Then press 0xF twice more and a third time -> value=0, count=0, no underflow.
5. After entering 4, 5, pulse 0xE during index-1 slot -> next edge value=0, count=0; following edge led_en=8'hFF. Repeat with KB_BLANK_EN undefined -> led_en keeps scanning and seg=8'hC0 ("0") in every slot.
6. Assert rst mid-dwell while count=5 and led_en=8'hF7 -> led_en=8'hFF, seg=8'hFF, count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared constants for the keypad digit display: key codes, buffer depth and
// active-high gfedcba seven-segment glyphs.
package kb_pkg;

  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_BSP = 4'hF;
  localparam int         DIGITS  = 8;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/kb_digit_display_if.sv
// Key-press link from the keypad scanner to the digit display.
// en is a one-cycle strobe with no back-pressure; num is valid only when en=1.
interface kb_digit_display_if;
  logic [3:0] num;
  logic       en;

  modport master (output num, output en);
  modport slave  (input  num, input  en);
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low {dp,g,f,e,d,c,b,a}; dp is held off.
module seg7_decode
  import kb_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_0;
    case (hex)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
  end

  assign seg = {1'b1, ~glyph};

endmodule

// File: rtl/kb_digit_display.sv
// Keypad entry buffer (8 hex digits, clear/backspace) multiplexed onto an
// 8-digit common-anode display. Define KB_BLANK_EN to blank unentered positions.
module kb_digit_display
  import kb_pkg::*;
#(
  parameter int SCAN_THRESHOLD = 200000 - 1,
  parameter int CNT_WIDTH      = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  kb_digit_display_if.slave        kb,
  output logic [7:0]               led_en,
  output logic [7:0]               seg,
  output logic [31:0]              value,
  output logic [3:0]               count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(SCAN_THRESHOLD);
  localparam logic [3:0]           CNT_FULL = 4'(DIGITS);

  logic [CNT_WIDTH-1:0] dwell_cnt;
  logic                 cnt_end;
  logic [2:0]           idx;
  logic [3:0]           nibble;
  logic [7:0]           seg_dec;
  logic                 visible;

  assign cnt_end = (dwell_cnt == CNT_MAX);

  // Free-running dwell counter and scan index; independent of key traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
      idx       <= 3'd0;
    end else if (cnt_end) begin
      dwell_cnt <= '0;
      idx       <= idx + 3'd1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 32'h0;
      count <= 4'd0;
    end else if (kb.en) begin
      case (kb.num)
        KEY_CLR: begin
          value <= 32'h0;
          count <= 4'd0;
        end
        KEY_BSP: begin
          // Backspace on an empty buffer is a no-op so count never underflows.
          if (count != 4'd0) begin
            value <= {4'h0, value[31:4]};
            count <= count - 4'd1;
          end
        end
        default: begin
          value <= {value[27:0], kb.num};
          if (count != CNT_FULL) count <= count + 4'd1;
        end
      endcase
    end
  end

  assign nibble = value[{idx, 2'b00} +: 4];

`ifdef KB_BLANK_EN
  assign visible = ({1'b0, idx} < count);
`else
  assign visible = 1'b1;
`endif

  seg7_decode u_seg7_decode (
    .hex (nibble),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_en <= 8'hFF;
      seg    <= SEG_BLANK;
    end else if (visible) begin
      led_en <= ~(8'b1 << idx);
      seg    <= seg_dec;
    end else begin
      led_en <= 8'hFF;
      seg    <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_kb_digit_display.sv
// Randomized and directed bench for kb_digit_display against a digit-queue
// reference model; scan position is derived from elapsed cycles.
module tb_kb_digit_display;

  localparam int TH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  led_en;
  logic [7:0]  seg;
  logic [31:0] value;
  logic [3:0]  count;

  always #5 clk = ~clk;

  kb_digit_display_if kb ();

  kb_digit_display #(.SCAN_THRESHOLD(TH), .CNT_WIDTH(24)) dut (
    .clk    (clk),
    .rst    (rst),
    .kb     (kb),
    .led_en (led_en),
    .seg    (seg),
    .value  (value),
    .count  (count)
  );

  // Reference state: q[0] is the rightmost (most recent) digit.
  logic [3:0]  q[$];
  int          t;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_led;
  logic [7:0]  exp_seg;
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_value();
    logic [31:0] v = 32'h0;
    for (int i = 0; i < q.size(); i++) v = v + (32'(q[i]) << (4 * i));
    return v;
  endfunction

  task automatic model_display(input int pos);
    logic       vis;
    logic [3:0] nib;
`ifdef KB_BLANK_EN
    vis = (pos < q.size());
`else
    vis = 1'b1;
`endif
    nib = (pos < q.size()) ? q[pos] : 4'h0;
    if (vis) begin
      exp_led = 8'hFF;
      exp_led[pos] = 1'b0;
      exp_seg = {1'b1, ~glyph[nib]};
    end else begin
      exp_led = 8'hFF;
      exp_seg = 8'hFF;
    end
  endtask

  task automatic model_key(input logic [3:0] k);
    if (k == 4'hE) q.delete();
    else if (k == 4'hF) begin
      if (q.size() > 0) void'(q.pop_front());
    end else begin
      q.push_front(k);
      if (q.size() > 8) void'(q.pop_back());
    end
  endtask

  // Called at a negedge: drive, take one clock, check at the next negedge.
  task automatic step(input logic e, input logic [3:0] k);
    kb.en  = e;
    kb.num = k;
    model_display((t / (TH + 1)) % 8);
    @(posedge clk);
    if (e) model_key(k);
    t++;
    @(negedge clk);
    check("value",  value,         model_value());
    check("count",  32'(count),    32'(q.size()));
    check("led_en", 32'(led_en),   32'(exp_led));
    check("seg",    32'(seg),      32'(exp_seg));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  task automatic do_reset();
    kb.en  = 1'b0;
    kb.num = 4'h0;
    rst    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_led_en", 32'(led_en), 32'hFF);
    check("rst_seg",    32'(seg),    32'hFF);
    check("rst_value",  value,       32'h0);
    check("rst_count",  32'(count),  32'h0);
    rst = 1'b0;
    q.delete();
    t = 0;
  endtask

  initial begin
    logic [3:0] seq[$];
    bit         hit;

    kb.en = 1'b0;
    kb.num = 4'h0;
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    idle(40);

    seq = '{4'h1, 4'h2, 4'h3};
    foreach (seq[i]) step(1'b1, seq[i]);
    idle(36);

    do_reset();
    for (int d = 1; d <= 9; d++) step(1'b1, 4'(d));
    idle(36);

    do_reset();
    seq = '{4'h1, 4'h2, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF};
    foreach (seq[i]) step(1'b1, seq[i]);
    idle(8);

    // Clear during the index-1 slot.
    do_reset();
    step(1'b1, 4'h4);
    step(1'b1, 4'h5);
    while (((t / (TH + 1)) % 8) != 1) step(1'b0, 4'h0);
    step(1'b1, 4'hE);
    idle(36);

    // Asynchronous reset mid-dwell with five digits entered.
    for (int d = 5; d >= 1; d--) step(1'b1, 4'(d));
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      step(1'b0, 4'h0);
      hit = (led_en == 8'hF7) && (TH > 0) && ((t % (TH + 1)) != TH);
    end
    check("reach_digit3", 32'(hit), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_led_en", 32'(led_en), 32'hFF);
    check("async_seg",    32'(seg),    32'hFF);
    check("async_count",  32'(count),  32'h0);
    check("async_value",  value,       32'h0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    t = 0;
    idle(10);

    // Random key traffic, including held strobes and repeated clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
